// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_pkg
// Brief    : Shared types and defaults for the double-buffered board store.
// Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

    localparam int CELL_COUNT_DEF = 4096;
    localparam int ADDR_W_DEF     = $clog2(CELL_COUNT_DEF);

    typedef logic bank_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/board_bram.sv
`default_nettype none
// ============================================================================
// Module   : board_bram
// Brief    : True dual-port cell array with a READ_LATENCY-deep output pipe.
// Revision : 1.0 - initial release
// ============================================================================
module board_bram
    import board_pkg::*;
#(
    parameter int DEPTH        = CELL_COUNT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              a_we_in,
    input  logic              a_re_in,
    input  logic [ADDR_W-1:0] a_addr_in,
    input  logic [DATA_W-1:0] a_wdata_in,
    output logic [DATA_W-1:0] a_rdata_out,
    input  logic              b_re_in,
    input  logic [ADDR_W-1:0] b_addr_in,
    output logic [DATA_W-1:0] b_rdata_out
);

    logic [DATA_W-1:0] r_mem    [DEPTH];
    logic [DATA_W-1:0] r_a_pipe [READ_LATENCY];
    logic [DATA_W-1:0] r_b_pipe [READ_LATENCY];

    // Stage 0 is the array read register; later stages only add delay.
    always_ff @(posedge clk_in) begin
        if (a_we_in) begin
            r_mem[a_addr_in] <= a_wdata_in;
        end
        if (a_re_in) begin
            r_a_pipe[0] <= r_mem[a_addr_in];
        end
        if (b_re_in) begin
            r_b_pipe[0] <= r_mem[b_addr_in];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_a_pipe[i] <= r_a_pipe[i-1];
            r_b_pipe[i] <= r_b_pipe[i-1];
        end
    end

    assign a_rdata_out = r_a_pipe[READ_LATENCY-1];
    assign b_rdata_out = r_b_pipe[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/board_buffer.sv
`default_nettype none
// ============================================================================
// Module   : board_buffer
// Brief    : Double-buffered Game of Life board store with swap/clear FSM.
// Revision : 1.0 - initial release
// ============================================================================
module board_buffer
    import board_pkg::*;
#(
    parameter  int CELL_COUNT    = CELL_COUNT_DEF,
    parameter  int DATA_W        = 1,
    parameter  int READ_LATENCY  = 2,
    parameter  int CLEAR_ON_SWAP = 1,
    localparam int ADDR_W        = $clog2(CELL_COUNT)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              buf_swap_in,
    output logic              buf_ready_out,
    input  logic [ADDR_W-1:0] logic_raddr_in,
    input  logic              logic_re_in,
    output logic [DATA_W-1:0] logic_rdata_out,
    output logic              logic_rvalid_out,
    input  logic [ADDR_W-1:0] logic_waddr_in,
    input  logic [DATA_W-1:0] logic_wdata_in,
    input  logic              logic_we_in,
    input  logic [ADDR_W-1:0] render_raddr_in,
    input  logic              render_re_in,
    output logic [DATA_W-1:0] render_rdata_out,
    output logic              render_rvalid_out,
    output logic              front_sel_out,
    output logic              swap_err_out
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(CELL_COUNT - 1);

    buf_state_t              r_state;
    bank_sel_t               r_front_sel;
    logic [ADDR_W-1:0]       r_clr_addr;
    logic                    r_ready;
    logic                    r_swap_err;
    logic [READ_LATENCY-1:0] r_logic_valid;
    logic [READ_LATENCY-1:0] r_logic_sel;
    logic [READ_LATENCY-1:0] r_render_valid;
    logic [READ_LATENCY-1:0] r_render_sel;

    logic                    w_back_we;
    logic [ADDR_W-1:0]       w_back_addr;
    logic [DATA_W-1:0]       w_back_wdata;
    logic [DATA_W-1:0]       w_a_rdata [2];
    logic [DATA_W-1:0]       w_b_rdata [2];

    // The back bank is written by the logic engine in IDLE and by the clearer in CLEAR.
    assign w_back_we    = ((r_state == IDLE) && logic_we_in) || (r_state == CLEAR);
    assign w_back_addr  = (r_state == CLEAR) ? r_clr_addr : logic_waddr_in;
    assign w_back_wdata = (r_state == CLEAR) ? '0 : logic_wdata_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_front_sel <= 1'b0;
            r_clr_addr  <= '0;
            r_ready     <= 1'b0;
            r_swap_err  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (buf_swap_in) begin
                        r_front_sel <= ~r_front_sel;
                        r_clr_addr  <= '0;
                        if (CLEAR_ON_SWAP != 0) begin
                            r_state <= CLEAR;
                        end else begin
                            r_state <= READY;
                            r_ready <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_last_addr) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if ((r_state != IDLE) && (buf_swap_in || logic_we_in)) begin
                r_swap_err <= 1'b1;
            end
        end
    end

    // Bank select travels with each read so in-flight reads survive a swap.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_logic_valid  <= '0;
            r_logic_sel    <= '0;
            r_render_valid <= '0;
            r_render_sel   <= '0;
        end else begin
            r_logic_valid[0]  <= logic_re_in;
            r_logic_sel[0]    <= r_front_sel;
            r_render_valid[0] <= render_re_in;
            r_render_sel[0]   <= r_front_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_logic_valid[i]  <= r_logic_valid[i-1];
                r_logic_sel[i]    <= r_logic_sel[i-1];
                r_render_valid[i] <= r_render_valid[i-1];
                r_render_sel[i]   <= r_render_sel[i-1];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_front;
        assign w_is_front = (r_front_sel == bank_sel_t'(b));

        board_bram #(
            .DEPTH        (CELL_COUNT),
            .ADDR_W       (ADDR_W),
            .DATA_W       (DATA_W),
            .READ_LATENCY (READ_LATENCY)
        ) u_bram (
            .clk_in      (clk_in),
            .a_we_in     (!w_is_front && w_back_we),
            .a_re_in     (w_is_front && logic_re_in),
            .a_addr_in   (w_is_front ? logic_raddr_in : w_back_addr),
            .a_wdata_in  (w_back_wdata),
            .a_rdata_out (w_a_rdata[b]),
            .b_re_in     (w_is_front && render_re_in),
            .b_addr_in   (render_raddr_in),
            .b_rdata_out (w_b_rdata[b])
        );
    end

    assign logic_rdata_out   = w_a_rdata[r_logic_sel[READ_LATENCY-1]];
    assign logic_rvalid_out  = r_logic_valid[READ_LATENCY-1];
    assign render_rdata_out  = w_b_rdata[r_render_sel[READ_LATENCY-1]];
    assign render_rvalid_out = r_render_valid[READ_LATENCY-1];
    assign buf_ready_out     = r_ready;
    assign front_sel_out     = r_front_sel;
    assign swap_err_out      = r_swap_err;

endmodule
`default_nettype wire

// File: tb/tb_board_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_buffer
// Brief    : Self-checking bench for board_buffer (16 cells, clear on swap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_buffer;

    localparam int CELLS = 16;
    localparam int LAT   = 2;
    localparam int AW    = 4;

    logic          clk_in, rst_n_in, buf_swap_in, buf_ready_out;
    logic [AW-1:0] logic_raddr_in, logic_waddr_in, render_raddr_in;
    logic          logic_re_in, logic_rdata_out, logic_rvalid_out;
    logic          logic_wdata_in, logic_we_in;
    logic          render_re_in, render_rdata_out, render_rvalid_out;
    logic          front_sel_out, swap_err_out;

    board_buffer #(
        .CELL_COUNT    (CELLS),
        .DATA_W        (1),
        .READ_LATENCY  (LAT),
        .CLEAR_ON_SWAP (1)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .buf_swap_in       (buf_swap_in),
        .buf_ready_out     (buf_ready_out),
        .logic_raddr_in    (logic_raddr_in),
        .logic_re_in       (logic_re_in),
        .logic_rdata_out   (logic_rdata_out),
        .logic_rvalid_out  (logic_rvalid_out),
        .logic_waddr_in    (logic_waddr_in),
        .logic_wdata_in    (logic_wdata_in),
        .logic_we_in       (logic_we_in),
        .render_raddr_in   (render_raddr_in),
        .render_re_in      (render_re_in),
        .render_rdata_out  (render_rdata_out),
        .render_rvalid_out (render_rvalid_out),
        .front_sel_out     (front_sel_out),
        .swap_err_out      (swap_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a swap is busy for CELLS+1 edges after acceptance,
    // the new back bank reads as zero, and ready fires CELLS edges later.
    typedef struct {
        int   due;
        logic d;
    } rd_t;

    rd_t  lq[$];
    rd_t  rq[$];
    logic m_bank [2][CELLS];
    logic m_front = 1'b0;
    logic m_err   = 1'b0;
    int   edge_n   = 0;
    int   ready_at = -1;
    int   busy_end = -1;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < CELLS; a++)
                m_bank[b][a] = 1'b0;
    end

    always @(posedge clk_in) begin
        rd_t tmp;
        bit  busy;
        edge_n++;
        if (!rst_n_in) begin
            m_front  = 1'b0;
            m_err    = 1'b0;
            ready_at = -1;
            busy_end = -1;
            lq.delete();
            rq.delete();
        end else begin
            busy = (edge_n <= busy_end);
            if (logic_re_in) begin
                tmp.due = edge_n + LAT - 1;
                tmp.d   = m_bank[m_front][logic_raddr_in];
                lq.push_back(tmp);
            end
            if (render_re_in) begin
                tmp.due = edge_n + LAT - 1;
                tmp.d   = m_bank[m_front][render_raddr_in];
                rq.push_back(tmp);
            end
            if (logic_we_in) begin
                if (busy) m_err = 1'b1;
                else      m_bank[~m_front][logic_waddr_in] = logic_wdata_in;
            end
            if (buf_swap_in) begin
                if (busy) begin
                    m_err = 1'b1;
                end else begin
                    m_front = ~m_front;
                    for (int a = 0; a < CELLS; a++) m_bank[~m_front][a] = 1'b0;
                    ready_at = edge_n + CELLS;
                    busy_end = edge_n + CELLS + 1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        bit ev;
        if (rst_n_in) begin
            check("ready", buf_ready_out, edge_n == ready_at);
            check("front_sel", front_sel_out, m_front);
            check("swap_err", swap_err_out, m_err);
            ev = (lq.size() > 0) && (lq[0].due == edge_n);
            check("logic_rvalid", logic_rvalid_out, ev);
            if (ev) begin
                check("logic_rdata", logic_rdata_out, lq[0].d);
                void'(lq.pop_front());
            end
            ev = (rq.size() > 0) && (rq[0].due == edge_n);
            check("render_rvalid", render_rvalid_out, ev);
            if (ev) begin
                check("render_rdata", render_rdata_out, rq[0].d);
                void'(rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pulses swap now and watches 30 cycles; disturb_at injects a swap + write mid-clear.
    task automatic swap_measure(input int disturb_at, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        buf_swap_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) begin
                buf_swap_in = 1'b0;
                logic_we_in = 1'b0;
            end
            if (i == disturb_at) begin
                buf_swap_in    = 1'b1;
                logic_we_in    = 1'b1;
                logic_waddr_in = 4'd4;
                logic_wdata_in = 1'b1;
            end else if (i == disturb_at + 1) begin
                buf_swap_in = 1'b0;
                logic_we_in = 1'b0;
            end
            if (buf_ready_out) begin
                if (first < 0) first = i;
                pulses++;
            end
        end
    endtask

    task automatic lread(input logic [AW-1:0] a, output logic d);
        logic_re_in    = 1'b1;
        logic_raddr_in = a;
        tick();
        logic_re_in = 1'b0;
        tick();
        d = logic_rdata_out;
    endtask

    task automatic write1(input logic [AW-1:0] a, input logic d);
        logic_we_in    = 1'b1;
        logic_waddr_in = a;
        logic_wdata_in = d;
        tick();
        logic_we_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   first, pulses;
        logic d;
        logic [AW-1:0] av;

        rst_n_in = 1'b0;    buf_swap_in = 1'b0;
        logic_re_in = 1'b0; logic_raddr_in = '0;
        logic_we_in = 1'b0; logic_waddr_in = '0; logic_wdata_in = 1'b0;
        render_re_in = 1'b0; render_raddr_in = '0;
        repeat (3) tick();
        check("rst_ready", buf_ready_out, 0);
        check("rst_front", front_sel_out, 0);
        check("rst_err", swap_err_out, 0);
        check("rst_lvalid", logic_rvalid_out, 0);
        check("rst_rvalid", render_rvalid_out, 0);
        rst_n_in = 1'b1;
        tick();

        // Write into back bank 1, swap, read back through both ports.
        write1(4'd5, 1'b1);
        write1(4'd7, 1'b1);
        swap_measure(0, first, pulses);
        check("A_latency", first, CELLS + 1);
        check("A_pulses", pulses, 1);
        check("A_front", front_sel_out, 1);
        render_re_in = 1'b1; render_raddr_in = 4'd5;
        tick();
        render_re_in = 1'b0;
        check("A_rvalid_early", render_rvalid_out, 0);
        tick();
        check("A_rvalid", render_rvalid_out, 1);
        check("A_rdata5", render_rdata_out, 1);
        lread(4'd7, d);
        check("A_ldata7", d, 1);

        // Render reads straddling a swap.
        write1(4'd2, 1'b1);
        render_re_in = 1'b1; render_raddr_in = 4'd5;
        tick();
        buf_swap_in = 1'b1;
        tick();
        buf_swap_in = 1'b0;
        check("B_rd_before_v", render_rvalid_out, 1);
        check("B_rd_before_d", render_rdata_out, 1);
        tick();
        render_re_in = 1'b0;
        check("B_rd_swap_d", render_rdata_out, 1);
        tick();
        check("B_rd_after_v", render_rvalid_out, 1);
        check("B_rd_after_d", render_rdata_out, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (buf_ready_out) pulses++;
        end
        check("B_pulses", pulses, 1);
        check("B_front", front_sel_out, 0);

        // Swap and write during CLEAR are ignored and flagged.
        swap_measure(12, first, pulses);
        check("C_latency", first, CELLS + 1);
        check("C_pulses", pulses, 1);
        check("C_err", swap_err_out, 1);
        check("C_front", front_sel_out, 1);

        // Same-cycle write and swap: write lands in the new front bank.
        logic_we_in = 1'b1; logic_waddr_in = 4'd3; logic_wdata_in = 1'b1;
        swap_measure(0, first, pulses);
        check("D_latency", first, CELLS + 1);
        check("D_front", front_sel_out, 0);
        lread(4'd3, d);
        check("D_ldata3", d, 1);
        lread(4'd4, d);
        check("D_dropped4", d, 0);
        lread(4'd2, d);
        check("D_cleared2", d, 0);

        // Asynchronous reset in the middle of a clear.
        buf_swap_in = 1'b1;
        tick();
        buf_swap_in = 1'b0;
        repeat (9) tick();
        check("E_front_pre", front_sel_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("E_async_front", front_sel_out, 0);
        check("E_async_ready", buf_ready_out, 0);
        check("E_async_err", swap_err_out, 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        swap_measure(0, first, pulses);
        check("E_latency", first, CELLS + 1);
        check("E_pulses", pulses, 1);
        check("E_front", front_sel_out, 1);

        // Full-bank pattern, read on both ports concurrently.
        for (int a = 0; a < CELLS; a++) begin
            av = a[AW-1:0];
            write1(av, av[0] ^ av[2]);
        end
        swap_measure(0, first, pulses);
        check("F_latency", first, CELLS + 1);
        for (int a = 0; a < CELLS; a++) begin
            logic_re_in  = 1'b1; logic_raddr_in  = a[AW-1:0];
            render_re_in = 1'b1; render_raddr_in = 4'(CELLS - 1 - a);
            tick();
        end
        logic_re_in  = 1'b0;
        render_re_in = 1'b0;
        repeat (3) tick();
        lread(4'd5, d);
        check("F_ldata5", d, 0);
        lread(4'd1, d);
        check("F_ldata1", d, 1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
